nand_phy_dq_calib: RTL and testbench

NAND_PHY_DQ_CALIB -- requirements
Module: nand_phy_dq_calib

---
 rtl/nand_phy_pkg.sv | 23 ++
 rtl/nand_phy_dq_tap_eval.sv | 77 +++++++
 rtl/nand_phy_dq_calib.sv | 206 ++++++++++++++++++++
 tb/tb_nand_phy_dq_calib.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/nand_phy_pkg.sv
// Shared definitions for the NAND PHY DQ read-capture calibration logic:
// FSM states, IDELAY tap range and the default training patterns.
package nand_phy_pkg;

  localparam int TAP_W = 5;
  localparam logic [TAP_W-1:0] TAP_MAX = 5'd31;

  localparam logic [7:0] PAT_RISE_DEF = 8'hA5;
  localparam logic [7:0] PAT_FALL_DEF = 8'h5A;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_DLY,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_INC,
    S_CENTER,
    S_DEC,
    S_DONE
  } cal_state_e;

endpackage

// File: rtl/nand_phy_dq_tap_eval.sv
// Judges one IDELAY tap: counts consecutive matching training words and
// reports a single-cycle pass or fail pulse (mismatch or rd_valid timeout).
module nand_phy_dq_tap_eval #(
  parameter int                  DQ_WIDTH    = 8,
  parameter logic [DQ_WIDTH-1:0] PAT_RISE    = '0,
  parameter logic [DQ_WIDTH-1:0] PAT_FALL    = '0,
  parameter int                  NUM_SAMPLES = 8,
  parameter int                  TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                start,
  input  logic                rd_valid,
  input  logic [DQ_WIDTH-1:0] rd_data_rise,
  input  logic [DQ_WIDTH-1:0] rd_data_fall,
  output logic                pass,
  output logic                fail
);

  localparam int MW = $clog2(NUM_SAMPLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [MW-1:0] MATCH_LAST   = MW'(NUM_SAMPLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

  logic [DQ_WIDTH-1:0] w_bit_err;
  logic                w_match;
  logic                r_armed;
  logic [MW-1:0]       r_match;
  logic [TW-1:0]       r_timeout;
  logic                r_pass;
  logic                r_fail;

  genvar gi;
  generate
    for (gi = 0; gi < DQ_WIDTH; gi++) begin : g_bit
      assign w_bit_err[gi] = (rd_data_rise[gi] != PAT_RISE[gi]) |
                             (rd_data_fall[gi] != PAT_FALL[gi]);
    end
  endgenerate

  assign w_match = ~|w_bit_err;

  always_ff @(posedge clk) begin
    if (srst || start) begin
      r_armed   <= start & ~srst;
      r_match   <= '0;
      r_timeout <= '0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_pass <= 1'b0;
      r_fail <= 1'b0;
      if (r_armed) begin
        if (rd_valid) begin
          if (!w_match) begin
            r_fail  <= 1'b1;
            r_armed <= 1'b0;
          end else if (r_match == MATCH_LAST) begin
            r_pass  <= 1'b1;
            r_armed <= 1'b0;
          end else begin
            r_match <= r_match + MW'(1);
          end
        end else if (r_timeout == TIMEOUT_LAST) begin
          r_fail  <= 1'b1;
          r_armed <= 1'b0;
        end else begin
          r_timeout <= r_timeout + TW'(1);
        end
      end
    end
  end

  assign pass = r_pass;
  assign fail = r_fail;

endmodule

// File: rtl/nand_phy_dq_calib.sv
// Byte-lane DQ read calibration: sweeps the IDELAY tap upward, records the
// first contiguous passing window, then steps back down to its centre.
module nand_phy_dq_calib
  import nand_phy_pkg::*;
#(
  parameter int                  DQ_WIDTH    = 8,
  parameter logic [DQ_WIDTH-1:0] PAT_RISE    = PAT_RISE_DEF,
  parameter logic [DQ_WIDTH-1:0] PAT_FALL    = PAT_FALL_DEF,
  parameter int                  NUM_SAMPLES = 8,
  parameter int                  SETTLE_CYC  = 4,
  parameter int                  TIMEOUT_CYC = 1024
) (
  input  logic                clk90,
  input  logic                rst90,
  input  logic                cal_start,
  input  logic                rd_valid,
  input  logic [DQ_WIDTH-1:0] rd_data_rise,
  input  logic [DQ_WIDTH-1:0] rd_data_fall,
  output logic                dlyrst,
  output logic                dlyce,
  output logic                dlyinc,
  output logic [TAP_W-1:0]    tap_value,
  output logic [TAP_W-1:0]    win_first,
  output logic [TAP_W-1:0]    win_last,
  output logic                cal_done,
  output logic                cal_fail
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  cal_state_e       r_state, w_state_next;
  logic [SW-1:0]    r_cnt, w_cnt_next;
  logic [TAP_W-1:0] r_tap, w_tap_next;
  logic [TAP_W-1:0] r_win_first, w_first_next;
  logic [TAP_W-1:0] r_win_last, w_last_next;
  logic             r_found, w_found_next;
  logic             r_passed, w_passed_next;
  logic             r_centering, w_centering_next;
  logic             r_cal_done, w_done_next;
  logic             r_cal_fail, w_fail_next;
  logic             r_dlyce, w_dlyce_next;
  logic             r_dlyinc, w_dlyinc_next;
  logic             r_dlyrst, w_dlyrst_next;
  logic             w_eval_start;
  logic             w_pass;
  logic             w_fail;
  logic [TAP_W:0]   w_sum;
  logic [TAP_W-1:0] w_target;

  nand_phy_dq_tap_eval #(
    .DQ_WIDTH    (DQ_WIDTH),
    .PAT_RISE    (PAT_RISE),
    .PAT_FALL    (PAT_FALL),
    .NUM_SAMPLES (NUM_SAMPLES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tap_eval (
    .clk          (clk90),
    .srst         (rst90),
    .start        (w_eval_start),
    .rd_valid     (rd_valid),
    .rd_data_rise (rd_data_rise),
    .rd_data_fall (rd_data_fall),
    .pass         (w_pass),
    .fail         (w_fail)
  );

  // Widened sum so taps 31+31 cannot overflow before halving.
  assign w_sum    = {1'b0, r_win_first} + {1'b0, r_win_last};
  assign w_target = w_sum[TAP_W:1];

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_tap_next       = r_tap;
    w_first_next     = r_win_first;
    w_last_next      = r_win_last;
    w_found_next     = r_found;
    w_passed_next    = r_passed;
    w_centering_next = r_centering;
    w_done_next      = r_cal_done;
    w_fail_next      = r_cal_fail;
    w_dlyce_next     = 1'b0;
    w_dlyinc_next    = 1'b0;
    w_dlyrst_next    = 1'b0;
    w_eval_start     = 1'b0;

    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (cal_start) begin
          w_state_next     = S_RST_DLY;
          w_tap_next       = '0;
          w_first_next     = '0;
          w_last_next      = '0;
          w_found_next     = 1'b0;
          w_centering_next = 1'b0;
          w_done_next      = 1'b0;
          w_fail_next      = 1'b0;
          w_dlyrst_next    = 1'b1;
        end
      end
      S_RST_DLY: begin
        w_state_next = S_SETTLE;
        w_cnt_next   = '0;
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          // During the centring walk-back the settle wait returns to CENTER.
          if (r_centering) begin
            w_state_next = S_CENTER;
          end else begin
            w_state_next = S_SAMPLE;
            w_eval_start = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + SW'(1);
        end
      end
      S_SAMPLE: begin
        if (w_pass || w_fail) begin
          w_passed_next = w_pass;
          w_state_next  = S_EVAL;
        end
      end
      S_EVAL: begin
        if (r_passed) begin
          if (!r_found) begin
            w_first_next = r_tap;
            w_found_next = 1'b1;
          end
          w_last_next = r_tap;
        end
        if ((!r_passed && r_found) || (r_tap == TAP_MAX)) begin
          w_state_next     = S_CENTER;
          w_centering_next = 1'b1;
        end else begin
          w_state_next  = S_INC;
          w_tap_next    = r_tap + TAP_W'(1);
          w_dlyce_next  = 1'b1;
          w_dlyinc_next = 1'b1;
        end
      end
      S_INC, S_DEC: begin
        w_state_next = S_SETTLE;
        w_cnt_next   = '0;
      end
      S_CENTER: begin
        if (!r_found) begin
          w_fail_next  = 1'b1;
          w_done_next  = 1'b1;
          w_state_next = S_DONE;
        end else if (r_tap > w_target) begin
          w_state_next = S_DEC;
          w_tap_next   = r_tap - TAP_W'(1);
          w_dlyce_next = 1'b1;
        end else begin
          w_done_next  = 1'b1;
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk90) begin
    if (rst90) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_tap       <= '0;
      r_win_first <= '0;
      r_win_last  <= '0;
      r_found     <= 1'b0;
      r_passed    <= 1'b0;
      r_centering <= 1'b0;
      r_cal_done  <= 1'b0;
      r_cal_fail  <= 1'b0;
      r_dlyce     <= 1'b0;
      r_dlyinc    <= 1'b0;
      r_dlyrst    <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_tap       <= w_tap_next;
      r_win_first <= w_first_next;
      r_win_last  <= w_last_next;
      r_found     <= w_found_next;
      r_passed    <= w_passed_next;
      r_centering <= w_centering_next;
      r_cal_done  <= w_done_next;
      r_cal_fail  <= w_fail_next;
      r_dlyce     <= w_dlyce_next;
      r_dlyinc    <= w_dlyinc_next;
      r_dlyrst    <= w_dlyrst_next;
    end
  end

  assign dlyrst    = r_dlyrst;
  assign dlyce     = r_dlyce;
  assign dlyinc    = r_dlyinc;
  assign tap_value = r_tap;
  assign win_first = r_win_first;
  assign win_last  = r_win_last;
  assign cal_done  = r_cal_done;
  assign cal_fail  = r_cal_fail;

endmodule

// File: tb/tb_nand_phy_dq_calib.sv
// Bench for nand_phy_dq_calib: an IDELAY/data-eye environment driven from the
// tap pulses, with expected results derived from the per-tap pass map.
module tb_nand_phy_dq_calib;

  localparam logic [7:0] PAT_R = 8'hA5;
  localparam logic [7:0] PAT_F = 8'h5A;

  logic       clk90 = 1'b0;
  logic       rst90;
  logic       cal_start;
  logic       rd_valid;
  logic [7:0] rd_data_rise;
  logic [7:0] rd_data_fall;
  logic       dlyrst, dlyce, dlyinc;
  logic [4:0] tap_value, win_first, win_last;
  logic       cal_done, cal_fail;

  nand_phy_dq_calib dut (
    .clk90        (clk90),
    .rst90        (rst90),
    .cal_start    (cal_start),
    .rd_valid     (rd_valid),
    .rd_data_rise (rd_data_rise),
    .rd_data_fall (rd_data_fall),
    .dlyrst       (dlyrst),
    .dlyce        (dlyce),
    .dlyinc       (dlyinc),
    .tap_value    (tap_value),
    .win_first    (win_first),
    .win_last     (win_last),
    .cal_done     (cal_done),
    .cal_fail     (cal_fail)
  );

  initial forever #5 clk90 = ~clk90;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Environment: which taps see a clean eye, plus the delay-line model.
  logic [31:0] env_mask  = '0;
  int          env_gtap  = -1;
  bit          env_dense = 1'b0;
  bit          env_stuck = 1'b0;
  int          m_tap     = 0;
  int          inc_cnt   = 0;
  int          dec_cnt   = 0;
  int          since     = 0;
  bit          wrap_err  = 1'b0;

  initial begin
    logic [7:0] flip;
    rd_valid     = 1'b0;
    rd_data_rise = '0;
    rd_data_fall = '0;
    forever begin
      @(negedge clk90);
      if (dlyce || dlyrst) check_eq("ce_rst_excl", 32'(dlyce & dlyrst), 0);
      if (dlyrst) begin
        m_tap = 0; inc_cnt = 0; dec_cnt = 0; since = 0; wrap_err = 1'b0;
      end else if (dlyce) begin
        since = 0;
        if (dlyinc) begin
          if (m_tap == 31) wrap_err = 1'b1; else m_tap++;
          inc_cnt++;
        end else begin
          if (m_tap == 0) wrap_err = 1'b1; else m_tap--;
          dec_cnt++;
        end
      end else begin
        since++;
      end
      if (env_stuck) rd_valid = 1'b0;
      else rd_valid = env_dense ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (env_mask[m_tap]) begin
        rd_data_rise = PAT_R;
        rd_data_fall = PAT_F;
        // 7th sample of the tap lands 11 cycles after its tap pulse.
        if (m_tap == env_gtap && since == 11) rd_data_rise = PAT_R ^ 8'h08;
      end else begin
        flip = 8'($urandom_range(1, 255));
        if ($urandom_range(0, 1) != 0) begin
          rd_data_rise = PAT_R ^ flip;
          rd_data_fall = PAT_F;
        end else begin
          rd_data_rise = PAT_R;
          rd_data_fall = PAT_F ^ flip;
        end
      end
    end
  end

  function automatic logic [31:0] range_mask(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int t = lo; t <= hi; t++) m[t] = 1'b1;
    return m;
  endfunction

  // Reference: first contiguous passing run; scan stops at first fail after it.
  task automatic model(input logic [31:0] mask, output int f, output int l,
                       output bit nopass, output int stop);
    bit found = 1'b0;
    f = 0; l = 0; stop = 31;
    for (int t = 0; t < 32; t++) begin
      if (mask[t]) begin
        if (!found) begin found = 1'b1; f = t; end
        l = t;
      end else if (found) begin
        stop = t;
        break;
      end
    end
    nopass = !found;
    if (nopass) begin f = 0; l = 0; end
  endtask

  task automatic run_cal(input string name, input logic [31:0] mask, input int gtap,
                         input bit dense, input bit stuck, input bit poke, input int bound);
    int f, l, stop, tgt, fin, cyc;
    bit nopass;
    logic [31:0] eff;
    env_mask = mask; env_gtap = gtap; env_dense = dense; env_stuck = stuck;
    eff = stuck ? 32'd0 : mask;
    if (gtap >= 0) eff[gtap] = 1'b0;
    model(eff, f, l, nopass, stop);
    tgt = (f + l) / 2;
    fin = nopass ? stop : tgt;
    @(posedge clk90); #1 cal_start = 1'b1;
    @(posedge clk90); #1 cal_start = 1'b0;
    cyc = 0;
    while (!cal_done && cyc < bound) begin
      @(posedge clk90); #1;
      cyc++;
      cal_start = (poke && cyc == 10);
    end
    cal_start = 1'b0;
    check_eq({name, "_done"}, 32'(cal_done), 1);
    check_eq({name, "_nopass"}, 32'(cal_fail), 32'(nopass));
    check_eq({name, "_first"}, 32'(win_first), f);
    check_eq({name, "_last"}, 32'(win_last), l);
    check_eq({name, "_tap"}, 32'(tap_value), fin);
    check_eq({name, "_dly_tap"}, m_tap, fin);
    check_eq({name, "_incs"}, inc_cnt, stop);
    check_eq({name, "_decs"}, dec_cnt, nopass ? 0 : stop - tgt);
    check_eq({name, "_nowrap"}, 32'(wrap_err), 0);
    repeat (8) @(posedge clk90);
    #1;
    check_eq({name, "_hold_done"}, 32'(cal_done), 1);
    check_eq({name, "_hold_tap"}, 32'(tap_value), fin);
    $display("%s: mask=%08h win=%0d..%0d tap=%0d nopass=%0d cycles=%0d",
             name, mask, win_first, win_last, tap_value, cal_fail, cyc);
  endtask

  initial begin
    logic [31:0] msk;
    int lo, hi, n;
    rst90 = 1'b1;
    cal_start = 1'b0;
    repeat (3) @(posedge clk90);
    #1;
    check_eq("rst_dlyrst", 32'(dlyrst), 1);
    check_eq("rst_dlyce", 32'(dlyce), 0);
    check_eq("rst_dlyinc", 32'(dlyinc), 0);
    check_eq("rst_tap", 32'(tap_value), 0);
    check_eq("rst_done", 32'(cal_done), 0);
    check_eq("rst_fail", 32'(cal_fail), 0);
    check_eq("rst_first", 32'(win_first), 0);
    check_eq("rst_last", 32'(win_last), 0);
    rst90 = 1'b0;
    @(posedge clk90); #1;
    check_eq("rel_dlyrst", 32'(dlyrst), 0);
    $display("reset: dlyrst=%0d tap=%0d done=%0d", dlyrst, tap_value, cal_done);

    run_cal("win5_12", range_mask(5, 12), -1, 1'b1, 1'b0, 1'b0, 3000);
    run_cal("nopass", 32'd0, -1, 1'b0, 1'b0, 1'b0, 3000);
    run_cal("top20_31", range_mask(20, 31), -1, 1'b0, 1'b0, 1'b0, 3000);
    run_cal("glitch9", range_mask(5, 12), 9, 1'b1, 1'b0, 1'b0, 3000);

    // Reset during the settle that follows the third increment.
    env_mask = range_mask(5, 12); env_gtap = -1; env_dense = 1'b1; env_stuck = 1'b0;
    @(posedge clk90); #1 cal_start = 1'b1;
    @(posedge clk90); #1 cal_start = 1'b0;
    n = 0;
    for (int c = 0; c < 2000 && n < 3; c++) begin
      @(posedge clk90); #1;
      if (dlyce && dlyinc) n++;
    end
    check_eq("mid_inc3_seen", n, 3);
    @(posedge clk90); #1 rst90 = 1'b1;
    @(posedge clk90); #1;
    check_eq("mid_rst_tap", 32'(tap_value), 0);
    check_eq("mid_rst_dlyrst", 32'(dlyrst), 1);
    check_eq("mid_rst_done", 32'(cal_done), 0);
    check_eq("mid_rst_dlyce", 32'(dlyce), 0);
    $display("midreset: tap=%0d dlyrst=%0d done=%0d", tap_value, dlyrst, cal_done);
    rst90 = 1'b0;
    @(posedge clk90); #1;
    check_eq("mid_rel_dlyrst", 32'(dlyrst), 0);
    run_cal("rerun5_12", range_mask(5, 12), -1, 1'b1, 1'b0, 1'b0, 3000);

    run_cal("poke_ignored", range_mask(2, 7), -1, 1'b0, 1'b0, 1'b1, 3000);

    for (int i = 0; i < 8; i++) begin
      lo = $urandom_range(0, 31);
      hi = $urandom_range(lo, 31);
      msk = ($urandom_range(0, 5) == 0) ? 32'd0 : range_mask(lo, hi);
      if (hi < 30 && msk != 0) msk = msk | (32'($urandom()) & range_mask(hi + 2, 31));
      run_cal($sformatf("rand%0d", i), msk, -1, 1'b0, 1'b0, 1'b0, 3000);
    end

    run_cal("stuck_invalid", range_mask(5, 12), -1, 1'b0, 1'b1, 1'b0, 40000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
